// File: rtl/port_failover.sv
// N-way redundant downstream-port select: per-port link debounce, hold-off failover,
// optional wait-to-restore, software force. Define PORT_FAILOVER_STATS_EN for counters.
module port_failover #(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLDOFF_CYCLES  = 8,
  parameter int unsigned REVERTIVE       = 0,
  localparam int unsigned SEL_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] link,
  input  logic                 force_en,
  input  logic [SEL_W-1:0]     force_sel,
  output logic [NUM_PORTS-1:0] link_db,
  output logic [SEL_W-1:0]     sel,
  output logic                 sel_valid,
  output logic                 switch_pulse,
  output logic [2:0]           state_o
`ifdef PORT_FAILOVER_STATS_EN
  ,
  output logic [15:0]          switch_count,
  output logic [15:0]          holdoff_count
`endif
);

  localparam int unsigned PAD_W = 1 << SEL_W;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMR_W = $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_NONE    = 3'd0,
    ST_ACTIVE  = 3'd1,
    ST_HOLDOFF = 3'd2,
    ST_RESTORE = 3'd3,
    ST_FORCED  = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [SEL_W-1:0]     sel_n;
  logic                 sel_valid_n;
  logic                 switch_pulse_n;
  logic [TMR_W-1:0]     timer, timer_n;
  logic [NUM_PORTS-1:0] link_db_n;
  logic [CNT_W-1:0]     db_cnt   [NUM_PORTS];
  logic [CNT_W-1:0]     db_cnt_n [NUM_PORTS];

  logic [PAD_W-1:0] db_pad, dbn_pad, sel_bit, lower_mask;
  logic [SEL_W:0]   lowest_all, lowest_other;
  logic             sel_up, lower_up, force_ok, expired;

  // {found, index} of the lowest set bit
  function automatic logic [SEL_W:0] lowest_up(input logic [PAD_W-1:0] mask);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = int'(PAD_W) - 1; i >= 0; i--) begin
      if (mask[i]) r = {1'b1, SEL_W'(i)};
    end
    return r;
  endfunction

  assign state_o = state;

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      state        <= ST_NONE;
      sel          <= '0;
      sel_valid    <= 1'b0;
      switch_pulse <= 1'b0;
      timer        <= '0;
      link_db      <= '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) db_cnt[i] <= '0;
    end else begin
      state        <= state_n;
      sel          <= sel_n;
      sel_valid    <= sel_valid_n;
      switch_pulse <= switch_pulse_n;
      timer        <= timer_n;
      link_db      <= link_db_n;
      for (int i = 0; i < int'(NUM_PORTS); i++) db_cnt[i] <= db_cnt_n[i];
    end
  end

  // Accept a raw change only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin : debounce_next
    link_db_n = link_db;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      db_cnt_n[i] = '0;
      if (link[i] != link_db[i]) begin
        if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) link_db_n[i] = link[i];
        else db_cnt_n[i] = db_cnt[i] + CNT_W'(1);
      end
    end
  end

  assign db_pad       = PAD_W'(link_db);
  assign dbn_pad      = PAD_W'(link_db_n);
  assign sel_bit      = PAD_W'(1) << sel;
  assign lower_mask   = sel_bit - PAD_W'(1);
  assign sel_up       = db_pad[sel];
  assign lower_up     = |(db_pad & lower_mask);
  assign lowest_all   = lowest_up(db_pad);
  assign lowest_other = lowest_up(db_pad & ~sel_bit);
  assign force_ok     = force_en && (32'(force_sel) < NUM_PORTS);
  assign expired      = (timer <= TMR_W'(1));

  always_comb begin : fsm_next
    state_n        = state;
    sel_n          = sel;
    timer_n        = timer;
    sel_valid_n    = 1'b0;
    switch_pulse_n = 1'b0;

    case (state)
      ST_NONE: begin
        if (lowest_all[SEL_W]) begin
          sel_n   = lowest_all[SEL_W-1:0];
          state_n = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (!sel_up) begin
          state_n = ST_HOLDOFF;
          timer_n = TMR_W'(HOLDOFF_CYCLES);
        end else if ((REVERTIVE != 0) && lower_up) begin
          state_n = ST_RESTORE;
          timer_n = TMR_W'(HOLDOFF_CYCLES);
        end
      end
      ST_HOLDOFF: begin
        if (sel_up) begin
          state_n = ST_ACTIVE;
          timer_n = '0;
        end else if (expired) begin
          timer_n = '0;
          if (lowest_other[SEL_W]) begin
            sel_n   = lowest_other[SEL_W-1:0];
            state_n = ST_ACTIVE;
          end else begin
            state_n = ST_NONE;
          end
        end else begin
          timer_n = timer - TMR_W'(1);
        end
      end
      ST_RESTORE: begin
        // losing the current port during wait-to-restore switches without hold-off
        if (!sel_up) begin
          timer_n = '0;
          if (lowest_all[SEL_W]) begin
            sel_n   = lowest_all[SEL_W-1:0];
            state_n = ST_ACTIVE;
          end else begin
            state_n = ST_NONE;
          end
        end else if (!lower_up) begin
          state_n = ST_ACTIVE;
          timer_n = '0;
        end else if (expired) begin
          sel_n   = lowest_all[SEL_W-1:0];
          state_n = ST_ACTIVE;
          timer_n = '0;
        end else begin
          timer_n = timer - TMR_W'(1);
        end
      end
      ST_FORCED: begin
        if (!force_en) begin
          if (sel_up) begin
            state_n = ST_ACTIVE;
          end else begin
            state_n = ST_HOLDOFF;
            timer_n = TMR_W'(HOLDOFF_CYCLES);
          end
        end else if (force_ok) begin
          sel_n = force_sel;
        end
      end
      default: begin
        state_n = ST_NONE;
        timer_n = '0;
      end
    endcase

    // force outranks every other event
    if (force_ok && (state != ST_FORCED)) begin
      state_n = ST_FORCED;
      sel_n   = force_sel;
      timer_n = '0;
    end

    case (state_n)
      ST_ACTIVE, ST_RESTORE: sel_valid_n = 1'b1;
      ST_FORCED:             sel_valid_n = dbn_pad[sel_n];
      default:               sel_valid_n = 1'b0;
    endcase

    switch_pulse_n = (sel_n != sel);
  end

`ifdef PORT_FAILOVER_STATS_EN
  logic hold_entry;
  assign hold_entry = (state_n == ST_HOLDOFF) && (state != ST_HOLDOFF);

  // Saturating event counters, updated together with the event they count
  always_ff @(posedge clk) begin : stats
    if (rst) begin
      switch_count  <= '0;
      holdoff_count <= '0;
    end else begin
      if (switch_pulse_n && (switch_count != 16'hFFFF)) switch_count <= switch_count + 16'd1;
      if (hold_entry && (holdoff_count != 16'hFFFF)) holdoff_count <= holdoff_count + 16'd1;
    end
  end
`else
  // statistics counters are not built
`endif

endmodule

// File: tb/tb_port_failover.sv
// Bench for port_failover: two instances (non-revertive / revertive) against a behavioural model.
module tb_port_failover;

  localparam int N = 3;
  localparam int D = 4;
  localparam int H = 8;

  typedef struct packed {
    logic [2:0]  mode;
    logic [1:0]  sel;
    logic        valid;
    logic        pulse;
    logic [7:0]  age;
    logic [15:0] swc;
    logic [15:0] hoc;
  } m_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] link = '0;
  logic       force_en = 1'b0;
  logic [1:0] force_sel = '0;

  logic [2:0] db_nr, db_rv, st_nr, st_rv;
  logic [1:0] sel_nr, sel_rv;
  logic       valid_nr, valid_rv, pulse_nr, pulse_rv;
`ifdef PORT_FAILOVER_STATS_EN
  logic [15:0] swc_nr, swc_rv, hoc_nr, hoc_rv;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  int pc_nr = 0;
  int pc_rv = 0;
  int snap;

  logic [11:0] hist = '0;
  int          nsamp = 0;
  logic [2:0]  mdb = '0;
  m_t          mnr = '0;
  m_t          mrv = '0;

  always #5 clk = ~clk;

  port_failover #(.NUM_PORTS(N), .DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(H), .REVERTIVE(0)) dut_nr (
    .clk(clk), .rst(rst), .link(link), .force_en(force_en), .force_sel(force_sel),
    .link_db(db_nr), .sel(sel_nr), .sel_valid(valid_nr), .switch_pulse(pulse_nr), .state_o(st_nr)
`ifdef PORT_FAILOVER_STATS_EN
    , .switch_count(swc_nr), .holdoff_count(hoc_nr)
`endif
  );

  port_failover #(.NUM_PORTS(N), .DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(H), .REVERTIVE(1)) dut_rv (
    .clk(clk), .rst(rst), .link(link), .force_en(force_en), .force_sel(force_sel),
    .link_db(db_rv), .sel(sel_rv), .sel_valid(valid_rv), .switch_pulse(pulse_rv), .state_o(st_rv)
`ifdef PORT_FAILOVER_STATS_EN
    , .switch_count(swc_rv), .holdoff_count(hoc_rv)
`endif
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A port's debounced level flips once the last D raw samples all disagree with it
  function automatic logic [2:0] db_next(logic [2:0] db, logic [11:0] h, int n);
    logic [2:0] r;
    bit all_diff;
    r = db;
    if (n >= D) begin
      for (int i = 0; i < N; i++) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++) if (h[3*k+i] == db[i]) all_diff = 1'b0;
        if (all_diff) r[i] = ~db[i];
      end
    end
    return r;
  endfunction

  function automatic int lowest(logic [2:0] m, int excl);
    for (int i = 0; i < N; i++) if (m[i] && i != excl) return i;
    return -1;
  endfunction

  // Modes: 0 none, 1 active, 2 hold-off, 3 restore, 4 forced; age = cycles elapsed in a timed mode
  function automatic m_t step(m_t c, logic [2:0] dbo, logic [2:0] dbn, logic fen, logic [1:0] fs, bit rev);
    m_t n;
    int p;
    n = c;
    p = lowest(dbo, -1);
    if (c.mode == 3'd4) begin
      if (!fen) begin
        if (dbo[c.sel]) n.mode = 3'd1;
        else begin n.mode = 3'd2; n.age = '0; end
      end else if (int'(fs) < N) n.sel = fs;
    end else if (fen && int'(fs) < N) begin
      n.mode = 3'd4;
      n.sel = fs;
    end else begin
      case (c.mode)
        3'd0: begin
          if (p >= 0) begin n.sel = 2'(p); n.mode = 3'd1; end
        end
        3'd1: begin
          if (!dbo[c.sel]) begin n.mode = 3'd2; n.age = '0; end
          else if (rev && p < int'(c.sel)) begin n.mode = 3'd3; n.age = '0; end
        end
        3'd2: begin
          if (dbo[c.sel]) n.mode = 3'd1;
          else if (int'(c.age) + 1 >= H) begin
            p = lowest(dbo, int'(c.sel));
            if (p >= 0) begin n.sel = 2'(p); n.mode = 3'd1; end
            else n.mode = 3'd0;
          end else n.age = c.age + 8'd1;
        end
        3'd3: begin
          if (!dbo[c.sel]) begin
            if (p >= 0) begin n.sel = 2'(p); n.mode = 3'd1; end
            else n.mode = 3'd0;
          end else if (p >= int'(c.sel)) n.mode = 3'd1;
          else if (int'(c.age) + 1 >= H) begin n.sel = 2'(p); n.mode = 3'd1; end
          else n.age = c.age + 8'd1;
        end
        default: ;
      endcase
    end
    if (n.mode == 3'd2 && c.mode != 3'd2 && c.hoc != 16'hFFFF) n.hoc = c.hoc + 16'd1;
    if (n.mode == 3'd1 || n.mode == 3'd3) n.valid = 1'b1;
    else if (n.mode == 3'd4) n.valid = dbn[n.sel];
    else n.valid = 1'b0;
    n.pulse = (n.sel != c.sel);
    if (n.pulse && c.swc != 16'hFFFF) n.swc = c.swc + 16'd1;
    return n;
  endfunction

  always @(posedge clk) begin : model
    if (rst) begin
      hist  <= '0;
      nsamp <= 0;
      mdb   <= '0;
      mnr   <= '0;
      mrv   <= '0;
    end else begin
      hist  <= {hist[8:0], link};
      nsamp <= (nsamp < D) ? nsamp + 1 : nsamp;
      mdb   <= db_next(mdb, {hist[8:0], link}, nsamp + 1);
      mnr   <= step(mnr, mdb, db_next(mdb, {hist[8:0], link}, nsamp + 1), force_en, force_sel, 1'b0);
      mrv   <= step(mrv, mdb, db_next(mdb, {hist[8:0], link}, nsamp + 1), force_en, force_sel, 1'b1);
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      check("nr_link_db", 16'(db_nr), 16'(mdb));
      check("nr_sel", 16'(sel_nr), 16'(mnr.sel));
      check("nr_sel_valid", 16'(valid_nr), 16'(mnr.valid));
      check("nr_switch_pulse", 16'(pulse_nr), 16'(mnr.pulse));
      check("nr_state", 16'(st_nr), 16'(mnr.mode));
      check("rv_link_db", 16'(db_rv), 16'(mdb));
      check("rv_sel", 16'(sel_rv), 16'(mrv.sel));
      check("rv_sel_valid", 16'(valid_rv), 16'(mrv.valid));
      check("rv_switch_pulse", 16'(pulse_rv), 16'(mrv.pulse));
      check("rv_state", 16'(st_rv), 16'(mrv.mode));
`ifdef PORT_FAILOVER_STATS_EN
      check("nr_switch_count", swc_nr, mnr.swc);
      check("nr_holdoff_count", hoc_nr, mnr.hoc);
      check("rv_switch_count", swc_rv, mrv.swc);
      check("rv_holdoff_count", hoc_rv, mrv.hoc);
`endif
      if (pulse_nr === 1'b1) pc_nr++;
      if (pulse_rv === 1'b1) pc_rv++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(3);
    chk_en = 1'b1;
    check("rst_state", 16'(st_nr), 16'd0);
    check("rst_sel_valid", 16'(valid_nr), 16'd0);
    check("rst_link_db", 16'(db_rv), 16'd0);
    rst = 1'b0;

    // debounce: link accepted after 4 samples, selection one cycle later
    link = 3'b001;
    cyc(4);
    check("db_after_4", 16'(db_nr), 16'b001);
    check("db_state_none", 16'(st_nr), 16'd0);
    cyc(1);
    check("first_sel", 16'(sel_nr), 16'd0);
    check("first_valid", 16'(valid_nr), 16'd1);
    check("first_pulse", 16'(pulse_nr), 16'd0);
    check("first_active", 16'(st_nr), 16'd1);

    // 3-cycle glitch on port 1 is filtered
    link = 3'b011;
    cyc(3);
    link = 3'b001;
    cyc(6);
    check("glitch_filtered", 16'(db_nr), 16'b001);

    // failover from port 0 to port 1 after the full hold-off
    link = 3'b011;
    cyc(8);
    snap = pc_nr;
    link = 3'b010;
    cyc(5);
    check("holdoff_entered", 16'(st_nr), 16'd2);
    check("holdoff_invalid", 16'(valid_nr), 16'd0);
    cyc(7);
    check("holdoff_last", 16'(st_nr), 16'd2);
    cyc(1);
    check("failover_sel", 16'(sel_nr), 16'd1);
    check("failover_pulse", 16'(pulse_nr), 16'd1);
    check("failover_active", 16'(st_nr), 16'd1);
    cyc(3);
    check("failover_one_pulse", 16'(pc_nr - snap), 16'd1);

    // port 0 returns: revertive instance restores, other stays on port 1
    link = 3'b011;
    cyc(5);
    check("restore_entered", 16'(st_rv), 16'd3);
    check("restore_valid", 16'(valid_rv), 16'd1);
    cyc(7);
    check("restore_last", 16'(sel_rv), 16'd1);
    cyc(1);
    check("restore_sel", 16'(sel_rv), 16'd0);
    check("restore_pulse", 16'(pulse_rv), 16'd1);
    cyc(4);
    check("nonrev_stays", 16'(sel_nr), 16'd1);

    // short loss on revertive's selected port recovers without a switch
    snap = pc_rv;
    link = 3'b010;
    cyc(6);
    link = 3'b011;
    cyc(1);
    check("recover_in_holdoff", 16'(st_rv), 16'd2);
    cyc(11);
    check("recover_sel", 16'(sel_rv), 16'd0);
    check("recover_active", 16'(st_rv), 16'd1);
    check("recover_no_pulse", 16'(pc_rv - snap), 16'd0);

    // force: out-of-range ignored, re-select while forced, release into hold-off
    force_en = 1'b1;
    force_sel = 2'd3;
    cyc(2);
    check("force3_ignored", 16'(st_nr), 16'd1);
    force_sel = 2'd2;
    cyc(1);
    check("force_sel", 16'(sel_nr), 16'd2);
    check("force_state", 16'(st_nr), 16'd4);
    check("force_valid", 16'(valid_nr), 16'd0);
    force_sel = 2'd3;
    cyc(2);
    check("forced3_keeps", 16'(sel_rv), 16'd2);
    force_sel = 2'd1;
    cyc(1);
    check("reforce_sel", 16'(sel_rv), 16'd1);
    check("reforce_valid", 16'(valid_rv), 16'd1);
    force_sel = 2'd2;
    cyc(1);
    force_en = 1'b0;
    cyc(1);
    check("release_holdoff", 16'(st_nr), 16'd2);
    cyc(10);
    check("release_switch", 16'(sel_nr), 16'd0);

    // all ports lost as one event, then a single port comes up
    link = 3'b000;
    cyc(20);
    check("all_down_none", 16'(st_rv), 16'd0);
    check("all_down_sel_holds", 16'(sel_rv), 16'd0);
    link = 3'b100;
    cyc(5);
    check("port2_sel", 16'(sel_nr), 16'd2);
    check("port2_pulse", 16'(pulse_nr), 16'd1);

    // reset in the middle of a hold-off
    link = 3'b000;
    cyc(7);
    check("pre_rst_holdoff", 16'(st_nr), 16'd2);
    rst = 1'b1;
    cyc(1);
    check("rst_mid_sel", 16'(sel_nr), 16'd0);
    check("rst_mid_state", 16'(st_nr), 16'd0);
    check("rst_mid_db", 16'(db_nr), 16'd0);
    rst = 1'b0;

    // mixed link/force patterns
    for (int k = 0; k < 40; k++) begin
      link = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) begin
        force_en = 1'b1;
        force_sel = 2'($urandom_range(0, 3));
      end else begin
        force_en = 1'b0;
      end
      cyc($urandom_range(1, 14));
    end
    force_en = 1'b0;

`ifdef PORT_FAILOVER_STATS_EN
    rst = 1'b1;
    link = 3'b001;
    cyc(2);
    rst = 1'b0;
    cyc(10);
    for (int k = 0; k < 5; k++) begin
      link = (k % 2 == 0) ? 3'b010 : 3'b001;
      cyc(20);
    end
    check("stats_switch_5", swc_nr, 16'd5);
    check("stats_holdoff_5", hoc_rv, 16'd5);
`endif

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
